// File: rtl/mmio_uc_responder.sv
// mmio_uc_responder
// Behavioural responder for the data cache's uncacheable read/write memory
// interfaces. It serves a 32-byte simulation register window at BASE_ADDR:
//   +0x00 TOHOST (RW), +0x08 FROMHOST (RW), +0x10 SCRATCH (RW),
//   +0x18 MTIME (RO, free-running, writes silently ignored).
// Ports:
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   rd_req_* / rd_resp_*      uncached read request / response channel
//   wr_req_* / wr_data_* /    uncached write request, data and response
//   wr_resp_*                   channels
//   tohost_valid_o, tohost_o  end-of-test pulse and current TOHOST value
// One transaction in flight per channel; read and write sides are independent.
module mmio_uc_responder #(
  parameter int                    ADDR_WIDTH = 40,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h4000_0000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr_i,
  input  logic [7:0]              rd_req_len_i,
  input  logic [2:0]              rd_req_size_i,
  input  logic [ID_WIDTH-1:0]     rd_req_id_i,
  input  logic [1:0]              rd_req_command_i,
  output logic [ID_WIDTH-1:0]     rd_req_base_id_o,
  output logic                    rd_resp_valid_o,
  input  logic                    rd_resp_ready_i,
  output logic [DATA_WIDTH-1:0]   rd_resp_data_o,
  output logic [ID_WIDTH-1:0]     rd_resp_id_o,
  output logic                    rd_resp_error_o,
  output logic                    rd_resp_last_o,
  input  logic                    wr_req_valid_i,
  output logic                    wr_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr_i,
  input  logic [7:0]              wr_req_len_i,
  input  logic [2:0]              wr_req_size_i,
  input  logic [ID_WIDTH-1:0]     wr_req_id_i,
  input  logic [1:0]              wr_req_command_i,
  output logic [ID_WIDTH-1:0]     wr_req_base_id_o,
  input  logic                    wr_data_valid_i,
  output logic                    wr_data_ready_o,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic                    wr_last_i,
  output logic                    wr_resp_valid_o,
  input  logic                    wr_resp_ready_i,
  output logic [ID_WIDTH-1:0]     wr_resp_id_o,
  output logic                    wr_resp_error_o,
  output logic                    wr_resp_is_atomic_o,
  output logic                    tohost_valid_o,
  output logic [63:0]             tohost_o
);

  localparam int         REP        = DATA_WIDTH / 64;
  localparam logic [1:0] CMD_READ   = 2'd0;
  localparam logic [1:0] CMD_WRITE  = 2'd1;
  localparam logic [1:0] CMD_ATOMIC = 2'd2;

  typedef enum logic       {R_IDLE, R_RESP}         rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  // Any request this window cannot serve as a single aligned beat of the
  // channel's own command. ATOMIC never matches either channel.
  function automatic logic req_bad(input logic [ADDR_WIDTH-1:0] addr,
                                   input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] cmd, input logic [1:0] want);
    logic mis;
    case (size)
      3'd1:    mis = addr[0];
      3'd2:    mis = |addr[1:0];
      3'd3:    mis = |addr[2:0];
      default: mis = 1'b0;
    endcase
    return (addr[ADDR_WIDTH-1:5] != BASE_ADDR[ADDR_WIDTH-1:5]) || mis ||
           (size > 3'd3) || (len != 8'd0) || (cmd != want);
  endfunction

  logic              rst_done_q;
  rstate_t           rd_state_q, rd_state_d;
  wstate_t           wr_state_q, wr_state_d;
  logic [63:0]       tohost_q, fromhost_q, scratch_q, mtime_q;
  logic [3:0][63:0]  regs_v;
  logic              rd_cap, wr_cap, wr_beat, commit;
  logic [63:0]       rd_data_q;
  logic [ID_WIDTH-1:0] rd_id_q, w_id_q;
  logic              rd_err_q, w_err_q, w_atomic_q, w_first_q;
  logic [1:0]        w_idx_q;
  logic [63:0]       w_merged;
  logic              tohost_valid_q;

  assign regs_v = {mtime_q, scratch_q, fromhost_q, tohost_q};

  // Holds the request readies low during reset and releases them one edge later.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) rst_done_q <= 1'b0;
    else         rst_done_q <= 1'b1;

  // Read FSM
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) rd_state_q <= R_IDLE;
    else         rd_state_q <= rd_state_d;

  always_comb begin
    rd_state_d      = rd_state_q;
    rd_req_ready_o  = 1'b0;
    rd_resp_valid_o = 1'b0;
    rd_cap          = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        rd_req_ready_o = rst_done_q;
        rd_cap         = rst_done_q && rd_req_valid_i;
        if (rd_cap) rd_state_d = R_RESP;
      end
      R_RESP: begin
        rd_resp_valid_o = 1'b1;
        if (rd_resp_ready_i) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Captured at the handshake edge, so a same-edge write is not visible.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      rd_data_q <= '0;
      rd_id_q   <= '0;
      rd_err_q  <= 1'b0;
    end else if (rd_cap) begin
      rd_id_q  <= rd_req_id_i;
      rd_err_q <= req_bad(rd_req_addr_i, rd_req_len_i, rd_req_size_i,
                          rd_req_command_i, CMD_READ);
      rd_data_q <= req_bad(rd_req_addr_i, rd_req_len_i, rd_req_size_i,
                           rd_req_command_i, CMD_READ) ? '0 : regs_v[rd_req_addr_i[4:3]];
    end

  assign rd_req_base_id_o = '0;
  assign rd_resp_data_o   = {REP{rd_data_q}};
  assign rd_resp_id_o     = rd_id_q;
  assign rd_resp_error_o  = rd_err_q;
  assign rd_resp_last_o   = rd_resp_valid_o;

  // Write FSM
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) wr_state_q <= W_IDLE;
    else         wr_state_q <= wr_state_d;

  always_comb begin
    wr_state_d      = wr_state_q;
    wr_req_ready_o  = 1'b0;
    wr_data_ready_o = 1'b0;
    wr_resp_valid_o = 1'b0;
    wr_cap          = 1'b0;
    wr_beat         = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        wr_req_ready_o = rst_done_q;
        wr_cap         = rst_done_q && wr_req_valid_i;
        if (wr_cap) wr_state_d = W_DATA;
      end
      W_DATA: begin
        wr_data_ready_o = 1'b1;
        wr_beat         = wr_data_valid_i;
        if (wr_beat && wr_last_i) wr_state_d = W_RESP;
      end
      W_RESP: begin
        wr_resp_valid_o = 1'b1;
        if (wr_resp_ready_i) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      w_idx_q    <= '0;
      w_id_q     <= '0;
      w_err_q    <= 1'b0;
      w_atomic_q <= 1'b0;
      w_first_q  <= 1'b0;
    end else if (wr_cap) begin
      w_idx_q    <= wr_req_addr_i[4:3];
      w_id_q     <= wr_req_id_i;
      w_err_q    <= req_bad(wr_req_addr_i, wr_req_len_i, wr_req_size_i,
                            wr_req_command_i, CMD_WRITE);
      w_atomic_q <= (wr_req_command_i == CMD_ATOMIC);
      w_first_q  <= 1'b1;
    end else if (wr_beat) begin
      w_first_q  <= 1'b0;
    end

  // Only the first beat of an error-free request touches the register file.
  assign commit = wr_beat && w_first_q && !w_err_q;

  always_comb begin
    w_merged = regs_v[w_idx_q];
    for (int b = 0; b < 8; b++)
      if (wr_be_i[b]) w_merged[8*b +: 8] = wr_data_i[8*b +: 8];
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      tohost_q       <= '0;
      fromhost_q     <= '0;
      scratch_q      <= '0;
      mtime_q        <= '0;
      tohost_valid_q <= 1'b0;
    end else begin
      mtime_q        <= mtime_q + 64'd1;
      tohost_valid_q <= commit && (w_idx_q == 2'd0) && w_merged[0];
      if (commit)
        case (w_idx_q)
          2'd0:    tohost_q   <= w_merged;
          2'd1:    fromhost_q <= w_merged;
          2'd2:    scratch_q  <= w_merged;
          default: ; // MTIME is read-only
        endcase
    end

  assign wr_req_base_id_o    = '0;
  assign wr_resp_id_o        = w_id_q;
  assign wr_resp_error_o     = w_err_q;
  assign wr_resp_is_atomic_o = w_atomic_q;
  assign tohost_valid_o      = tohost_valid_q;
  assign tohost_o            = tohost_q;

endmodule

// File: tb/tb_mmio_uc_responder.sv
// Self-checking bench for mmio_uc_responder: a table of single-beat
// transactions with explicit expected results, scoreboard queues for the
// response channels, and hand-written sequences for MTIME, draining,
// back-pressure and mid-transaction reset.
module tb_mmio_uc_responder;
  localparam logic [39:0] B = 40'h00_4000_0000;

  logic        clk_i = 1'b0, rstn_i = 1'b0;
  logic        rd_req_valid_i = 0, rd_req_ready_o;
  logic [39:0] rd_req_addr_i = '0;
  logic [7:0]  rd_req_len_i = '0;
  logic [2:0]  rd_req_size_i = '0;
  logic [3:0]  rd_req_id_i = '0;
  logic [1:0]  rd_req_command_i = '0;
  logic [3:0]  rd_req_base_id_o;
  logic        rd_resp_valid_o, rd_resp_ready_i = 1'b1;
  logic [63:0] rd_resp_data_o;
  logic [3:0]  rd_resp_id_o;
  logic        rd_resp_error_o, rd_resp_last_o;
  logic        wr_req_valid_i = 0, wr_req_ready_o;
  logic [39:0] wr_req_addr_i = '0;
  logic [7:0]  wr_req_len_i = '0;
  logic [2:0]  wr_req_size_i = '0;
  logic [3:0]  wr_req_id_i = '0;
  logic [1:0]  wr_req_command_i = '0;
  logic [3:0]  wr_req_base_id_o;
  logic        wr_data_valid_i = 0, wr_data_ready_o;
  logic [63:0] wr_data_i = '0;
  logic [7:0]  wr_be_i = '0;
  logic        wr_last_i = 0;
  logic        wr_resp_valid_o, wr_resp_ready_i = 1'b1;
  logic [3:0]  wr_resp_id_o;
  logic        wr_resp_error_o, wr_resp_is_atomic_o;
  logic        tohost_valid_o;
  logic [63:0] tohost_o;

  mmio_uc_responder dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rd_req_addr_i(rd_req_addr_i), .rd_req_len_i(rd_req_len_i),
    .rd_req_size_i(rd_req_size_i), .rd_req_id_i(rd_req_id_i),
    .rd_req_command_i(rd_req_command_i), .rd_req_base_id_o(rd_req_base_id_o),
    .rd_resp_valid_o(rd_resp_valid_o), .rd_resp_ready_i(rd_resp_ready_i),
    .rd_resp_data_o(rd_resp_data_o), .rd_resp_id_o(rd_resp_id_o),
    .rd_resp_error_o(rd_resp_error_o), .rd_resp_last_o(rd_resp_last_o),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
    .wr_req_addr_i(wr_req_addr_i), .wr_req_len_i(wr_req_len_i),
    .wr_req_size_i(wr_req_size_i), .wr_req_id_i(wr_req_id_i),
    .wr_req_command_i(wr_req_command_i), .wr_req_base_id_o(wr_req_base_id_o),
    .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_o(wr_data_ready_o),
    .wr_data_i(wr_data_i), .wr_be_i(wr_be_i), .wr_last_i(wr_last_i),
    .wr_resp_valid_o(wr_resp_valid_o), .wr_resp_ready_i(wr_resp_ready_i),
    .wr_resp_id_o(wr_resp_id_o), .wr_resp_error_o(wr_resp_error_o),
    .wr_resp_is_atomic_o(wr_resp_is_atomic_o),
    .tohost_valid_o(tohost_valid_o), .tohost_o(tohost_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [63:0] data; logic [3:0] id; logic err; logic ck; } rexp_t;
  typedef struct { logic [3:0] id; logic err; logic atomic; } wexp_t;
  typedef struct {
    logic wr; logic [39:0] addr; logic [2:0] size; logic [7:0] len; logic [1:0] cmd;
    logic [3:0] id; logic [63:0] data; logic [7:0] be; logic err; logic [63:0] exp;
  } vec_t;

  rexp_t rq[$];
  wexp_t wq[$];
  int total = 0, bad = 0, beats = 0, pulses = 0;
  logic [63:0] last_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++; bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Response monitor / scoreboard
  always @(negedge clk_i) begin : mon
    rexp_t re;
    wexp_t we;
    if (rstn_i) begin
      if (rd_resp_valid_o && rd_resp_ready_i) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got id %h want none", rd_resp_id_o);
        end else begin
          re = rq.pop_front();
          chk("rd_id", 64'(rd_resp_id_o), 64'(re.id));
          chk("rd_err", 64'(rd_resp_error_o), 64'(re.err));
          chk("rd_last", 64'(rd_resp_last_o), 64'd1);
          if (re.ck) chk("rd_data", rd_resp_data_o, re.data);
        end
        last_rd = rd_resp_data_o;
      end
      if (wr_resp_valid_o && wr_resp_ready_i) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got id %h want none", wr_resp_id_o);
        end else begin
          we = wq.pop_front();
          chk("wr_id", 64'(wr_resp_id_o), 64'(we.id));
          chk("wr_err", 64'(wr_resp_error_o), 64'(we.err));
          chk("wr_atomic", 64'(wr_resp_is_atomic_o), 64'(we.atomic));
        end
      end
      if (wr_data_valid_i && wr_data_ready_o) beats++;
      if (tohost_valid_o) pulses++;
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic do_read(input logic [39:0] a, input logic [2:0] sz, input logic [7:0] ln,
                         input logic [1:0] cmd, input logic [3:0] id, input logic err,
                         input logic [63:0] exp, input logic ck, output int hs);
    int n = 0;
    rexp_t e;
    rd_req_addr_i = a; rd_req_size_i = sz; rd_req_len_i = ln;
    rd_req_command_i = cmd; rd_req_id_i = id; rd_req_valid_i = 1'b1;
    hs = 0;
    while (!rd_req_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) begin tmo("rd_req"); rd_req_valid_i = 1'b0; return; end
    hs = cyc;
    e.data = exp; e.id = id; e.err = err; e.ck = ck;
    rq.push_back(e);
    @(negedge clk_i);
    rd_req_valid_i = 1'b0;
    chk("rd_latency", 64'(rd_resp_valid_o), 64'd1);
  endtask

  task automatic do_write(input logic [39:0] a, input logic [2:0] sz, input logic [7:0] ln,
                          input logic [1:0] cmd, input logic [3:0] id, input logic [63:0] d,
                          input logic [7:0] be, input logic err, input logic atom,
                          input logic pre);
    int n = 0;
    wexp_t e;
    if (pre) begin
      wr_data_i = d; wr_be_i = be; wr_last_i = (ln == 8'd0); wr_data_valid_i = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("wr_data_early", 64'(wr_data_ready_o), 64'd0);
    end
    wr_req_addr_i = a; wr_req_size_i = sz; wr_req_len_i = ln;
    wr_req_command_i = cmd; wr_req_id_i = id; wr_req_valid_i = 1'b1;
    while (!wr_req_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) begin tmo("wr_req"); wr_req_valid_i = 1'b0; wr_data_valid_i = 1'b0; return; end
    e.id = id; e.err = err; e.atomic = atom;
    wq.push_back(e);
    @(negedge clk_i);
    wr_req_valid_i = 1'b0;
    for (int i = 0; i <= int'(ln); i++) begin
      wr_data_i = (i == 0) ? d : ~d; wr_be_i = be;
      wr_last_i = (i == int'(ln)); wr_data_valid_i = 1'b1;
      n = 0;
      while (!wr_data_ready_o && n < 50) begin @(negedge clk_i); n++; end
      if (n >= 50) begin tmo("wr_data"); break; end
      @(negedge clk_i);
    end
    wr_data_valid_i = 1'b0; wr_last_i = 1'b0;
    chk("wr_latency", 64'(wr_resp_valid_o), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 60) begin @(negedge clk_i); n++; end
    if (n >= 60) begin tmo("response"); rq.delete(); wq.delete(); end
  endtask

  function automatic vec_t v(input logic wr, input logic [39:0] a, input logic [2:0] sz,
                             input logic [7:0] ln, input logic [1:0] cmd, input logic [3:0] id,
                             input logic [63:0] d, input logic [7:0] be, input logic err,
                             input logic [63:0] exp);
    vec_t r;
    r.wr = wr; r.addr = a; r.size = sz; r.len = ln; r.cmd = cmd; r.id = id;
    r.data = d; r.be = be; r.err = err; r.exp = exp;
    return r;
  endfunction

  localparam int NV = 18;
  vec_t vt[NV];

  initial begin : main
    int h1, h2, h3, b0;
    logic [63:0] t1, t2, t3;

    // wr  addr          sz len cmd id data                    be     err exp
    vt[0]  = v(1, B+40'h00, 3, 0, 1, 5,  64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0);
    vt[1]  = v(1, B+40'h10, 3, 0, 1, 1,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
    vt[2]  = v(1, B+40'h10, 3, 0, 1, 2,  64'h1111_1111_2222_2222, 8'h0F, 0, 0);
    vt[3]  = v(0, B+40'h10, 3, 0, 0, 3,  0, 0, 0, 64'hFFFF_FFFF_2222_2222);
    vt[4]  = v(0, B+40'h00, 3, 0, 0, 4,  0, 0, 0, 64'hDEAD_BEEF_0000_0001);
    vt[5]  = v(0, B+40'h20, 3, 0, 0, 6,  0, 0, 1, 0);
    vt[6]  = v(1, B+40'h04, 3, 0, 1, 7,  64'h0, 8'hFF, 1, 0);
    vt[7]  = v(1, B+40'h08, 3, 0, 1, 8,  64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0);
    vt[8]  = v(1, B+40'h0C, 2, 0, 1, 9,  64'hAAAA_AAAA_5555_5555, 8'hF0, 0, 0);
    vt[9]  = v(0, B+40'h08, 3, 0, 0, 10, 0, 0, 0, 64'hAAAA_AAAA_89AB_CDEF);
    vt[10] = v(0, B+40'h00, 4, 0, 0, 11, 0, 0, 1, 0);
    vt[11] = v(0, B+40'h10, 3, 0, 1, 12, 0, 0, 1, 0);
    vt[12] = v(1, B+40'h10, 3, 0, 0, 13, 64'h0, 8'hFF, 1, 0);
    vt[13] = v(0, B-40'h08, 3, 0, 0, 14, 0, 0, 1, 0);
    vt[14] = v(0, B+40'h02, 1, 0, 0, 15, 0, 0, 0, 64'hDEAD_BEEF_0000_0001);
    vt[15] = v(0, B+40'h10, 3, 1, 0, 1,  0, 0, 1, 0);
    vt[16] = v(0, B+40'h00, 3, 0, 0, 2,  0, 0, 0, 64'hDEAD_BEEF_0000_0001);
    vt[17] = v(0, B+40'h10, 3, 0, 0, 3,  0, 0, 0, 64'hFFFF_FFFF_2222_2222);

    // reset state
    repeat (3) @(negedge clk_i);
    chk("rst_rd_req_ready", 64'(rd_req_ready_o), 0);
    chk("rst_wr_req_ready", 64'(wr_req_ready_o), 0);
    chk("rst_rd_resp_valid", 64'(rd_resp_valid_o), 0);
    chk("rst_wr_resp_valid", 64'(wr_resp_valid_o), 0);
    chk("rst_tohost", tohost_o, 0);
    chk("rst_rd_data", rd_resp_data_o, 0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("rel_rd_req_ready", 64'(rd_req_ready_o), 1);
    chk("rel_wr_req_ready", 64'(wr_req_ready_o), 1);
    chk("base_id", 64'({rd_req_base_id_o, wr_req_base_id_o}), 0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].wr)
        do_write(vt[i].addr, vt[i].size, vt[i].len, vt[i].cmd, vt[i].id, vt[i].data,
                 vt[i].be, vt[i].err, vt[i].cmd == 2'd2, 1'b0);
      else
        do_read(vt[i].addr, vt[i].size, vt[i].len, vt[i].cmd, vt[i].id, vt[i].err,
                vt[i].exp, !vt[i].err, h1);
      wait_idle();
    end
    chk("tohost_value", tohost_o, 64'hDEAD_BEEF_0000_0001);
    chk("tohost_pulses", 64'(pulses), 1);

    // MTIME: two reads ten cycles apart, then a write that must not disturb it
    do_read(B+40'h18, 3, 0, 0, 1, 0, 0, 0, h1); wait_idle(); t1 = last_rd;
    while (cyc < h1 + 10) @(negedge clk_i);
    do_read(B+40'h18, 3, 0, 0, 2, 0, 0, 0, h2); wait_idle(); t2 = last_rd;
    chk("mtime_diff", t2 - t1, 64'd10);
    do_write(B+40'h18, 3, 0, 1, 3, 64'h0, 8'hFF, 0, 0, 0); wait_idle();
    do_read(B+40'h18, 3, 0, 0, 4, 0, 0, 0, h3); wait_idle(); t3 = last_rd;
    chk("mtime_ro", t3, t2 + 64'(h3 - h2));

    // 4-beat write with data ahead of the request: drained, one error response
    b0 = beats;
    do_write(B+40'h10, 3, 3, 1, 6, 64'h5555_5555_5555_5555, 8'hFF, 1, 0, 1); wait_idle();
    chk("drain_beats", 64'(beats - b0), 64'd4);
    do_write(B+40'h10, 3, 0, 2, 7, 64'h0, 8'hFF, 1, 1, 0); wait_idle();
    do_read(B+40'h10, 3, 0, 2, 8, 1, 0, 0, h1); wait_idle();
    do_read(B+40'h10, 3, 0, 0, 9, 0, 64'hFFFF_FFFF_2222_2222, 1, h1); wait_idle();

    // read response back-pressure
    rd_resp_ready_i = 1'b0;
    do_read(B+40'h10, 3, 0, 0, 9, 0, 64'hFFFF_FFFF_2222_2222, 1, h1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rd_valid", 64'(rd_resp_valid_o), 1);
      chk("bp_rd_data", rd_resp_data_o, 64'hFFFF_FFFF_2222_2222);
      chk("bp_rd_id", 64'(rd_resp_id_o), 9);
      chk("bp_rd_req_ready", 64'(rd_req_ready_o), 0);
      @(negedge clk_i);
    end
    rd_resp_ready_i = 1'b1;
    wait_idle();
    chk("bp_rd_ready_back", 64'(rd_req_ready_o), 1);

    // write response back-pressure
    wr_resp_ready_i = 1'b0;
    do_write(B+40'h08, 3, 0, 1, 10, 64'h77, 8'hFF, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_wr_valid", 64'(wr_resp_valid_o), 1);
      chk("bp_wr_id", 64'(wr_resp_id_o), 10);
      chk("bp_wr_req_ready", 64'(wr_req_ready_o), 0);
      @(negedge clk_i);
    end
    wr_resp_ready_i = 1'b1;
    wait_idle();
    chk("bp_wr_ready_back", 64'(wr_req_ready_o), 1);

    // reset while in W_DATA: transaction abandoned
    wr_req_addr_i = B + 40'h10; wr_req_size_i = 3; wr_req_len_i = 0;
    wr_req_command_i = 1; wr_req_id_i = 11; wr_req_valid_i = 1'b1;
    @(negedge clk_i);
    wr_req_valid_i = 1'b0;
    chk("mid_wr_data_ready", 64'(wr_data_ready_o), 1);
    rstn_i = 1'b0;
    #1;
    chk("mid_rst_wr_req_ready", 64'(wr_req_ready_o), 0);
    chk("mid_rst_wr_data_ready", 64'(wr_data_ready_o), 0);
    chk("mid_rst_tohost", tohost_o, 0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("post_wr_req_ready", 64'(wr_req_ready_o), 1);
    chk("post_rd_req_ready", 64'(rd_req_ready_o), 1);
    for (int k = 0; k < 4; k++) begin
      chk("post_valids", 64'({wr_resp_valid_o, rd_resp_valid_o, tohost_valid_o}), 0);
      @(negedge clk_i);
    end
    do_read(B+40'h10, 3, 0, 0, 12, 0, 64'h0, 1, h1); wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
